// File: rtl/spectrum_frame_sched.sv
// Frame round-robin scheduler: two FFT streams into one magnitude pipe.
// Optional stall padding enabled by defining SPEC_SCHED_TIMEOUT_EN.
module spectrum_frame_sched #(
  parameter int FRAME_LEN   = 1024,
  parameter int PIPE_LAT    = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_dout_i,
  input  logic        a_valid_i,
  input  logic        a_last_i,
  output logic        a_ready_o,
  input  logic [31:0] b_dout_i,
  input  logic        b_valid_i,
  input  logic        b_last_i,
  output logic        b_ready_o,
  output logic [31:0] mag_in_dout_o,
  output logic        mag_in_valid_o,
  output logic        mag_in_last_o,
  output logic        wr_chan_o,
  output logic        wr_valid_o,
  output logic        frame_done_a_o,
  output logic        frame_done_b_o,
  output logic        last_err_o,
  output logic        timeout_flag_o,
  output logic        busy_o
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

`ifdef SPEC_SCHED_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, XFER, PAD} state_t;
  logic [SW-1:0] stall_q;
  logic          tmo_q;
`else
  typedef enum logic [0:0] {IDLE, XFER} state_t;
`endif

  state_t        state_q;
  logic          grant_q;
  logic          served_q;
  logic [CW-1:0] beat_q;
  logic [31:0]   dout_q;
  logic          mvalid_q;
  logic          mlast_q;
  logic          mchan_q;
  logic          lerr_q;
  logic [2:0]    dl_q [PIPE_LAT];

  logic        in_xfer;
  logic        src_valid;
  logic        src_last;
  logic [31:0] src_dout;
  logic        acc;
  logic        at_end;

  assign in_xfer   = (state_q == XFER);
  assign src_valid = grant_q ? b_valid_i : a_valid_i;
  assign src_last  = grant_q ? b_last_i : a_last_i;
  assign src_dout  = grant_q ? b_dout_i : a_dout_i;
  assign acc       = in_xfer && src_valid;
  assign at_end    = (beat_q == LAST_BEAT);

  assign a_ready_o      = in_xfer && !grant_q;
  assign b_ready_o      = in_xfer && grant_q;
  assign busy_o         = (state_q != IDLE);
  assign mag_in_dout_o  = dout_q;
  assign mag_in_valid_o = mvalid_q;
  assign mag_in_last_o  = mlast_q;
  assign last_err_o     = lerr_q;

  // Grant, beat forwarding and frame accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      served_q <= 1'b1;
      beat_q   <= '0;
      dout_q   <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      mchan_q  <= 1'b0;
      lerr_q   <= 1'b0;
`ifdef SPEC_SCHED_TIMEOUT_EN
      stall_q  <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (a_valid_i || b_valid_i) begin
            grant_q <= (a_valid_i && b_valid_i) ? !served_q : b_valid_i;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (acc) begin
            dout_q   <= src_dout;
            mvalid_q <= 1'b1;
            mlast_q  <= at_end;
            mchan_q  <= grant_q;
            if (src_last != at_end) lerr_q <= 1'b1;
`ifdef SPEC_SCHED_TIMEOUT_EN
            stall_q <= '0;
`endif
            if (at_end) begin
              state_q  <= IDLE;
              beat_q   <= '0;
              served_q <= grant_q;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
`ifdef SPEC_SCHED_TIMEOUT_EN
          else if (stall_q == STALL_MAX) begin
            state_q <= PAD;
            tmo_q   <= 1'b1;
            stall_q <= '0;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
`ifdef SPEC_SCHED_TIMEOUT_EN
        PAD: begin
          dout_q   <= '0;
          mvalid_q <= 1'b1;
          mlast_q  <= at_end;
          mchan_q  <= grant_q;
          if (at_end) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            served_q <= grant_q;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPEC_SCHED_TIMEOUT_EN
  assign timeout_flag_o = tmo_q;
`else
  assign timeout_flag_o = 1'b0;
`endif

  // Delay {valid,last,chan} to line up with magnitude output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= {mvalid_q, mlast_q, mchan_q};
      for (int i = 1; i < PIPE_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign wr_valid_o     = dl_q[PIPE_LAT-1][2];
  assign wr_chan_o      = dl_q[PIPE_LAT-1][0];
  assign frame_done_a_o = dl_q[PIPE_LAT-1][2] && dl_q[PIPE_LAT-1][1]
                        && !dl_q[PIPE_LAT-1][0];
  assign frame_done_b_o = dl_q[PIPE_LAT-1][2] && dl_q[PIPE_LAT-1][1]
                        && dl_q[PIPE_LAT-1][0];

endmodule

// File: tb/tb_spectrum_frame_sched.sv
// Directed bench for spectrum_frame_sched.
// Scoreboard on mag_in beats, counters on tag-path pulses.
module tb_spectrum_frame_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] a_dout, b_dout;
  logic a_valid, a_last, b_valid, b_last;
  logic a_ready, b_ready;
  logic [31:0] mag_in_dout;
  logic mag_in_valid, mag_in_last;
  logic wr_chan, wr_valid, frame_done_a, frame_done_b;
  logic last_err, timeout_flag, busy;

  spectrum_frame_sched #(
    .FRAME_LEN(1024), .PIPE_LAT(5), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_dout_i(a_dout), .a_valid_i(a_valid),
    .a_last_i(a_last), .a_ready_o(a_ready),
    .b_dout_i(b_dout), .b_valid_i(b_valid),
    .b_last_i(b_last), .b_ready_o(b_ready),
    .mag_in_dout_o(mag_in_dout),
    .mag_in_valid_o(mag_in_valid),
    .mag_in_last_o(mag_in_last),
    .wr_chan_o(wr_chan), .wr_valid_o(wr_valid),
    .frame_done_a_o(frame_done_a),
    .frame_done_b_o(frame_done_b),
    .last_err_o(last_err),
    .timeout_flag_o(timeout_flag),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [31:0] q [$];
  logic [31:0] e;
  logic [31:0] seq = 0;
  int fb = 0, acc_fb = 0, fin_cyc = 0, last_lat = 0;
  bit fin_ok = 0, gap_chk = 0, had;
  int out_beats = 0, last_cnt = 0, pad_cnt = 0, wr_cnt = 0;
  int done_a = 0, done_b = 0;
  int data_err = 0, len_err = 0, lat_err = 0, gap_err = 0;

  // Scoreboard and pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      fb = 0; acc_fb = 0; fin_ok = 0; gap_chk = 0;
    end else begin
      if (gap_chk && (a_ready || b_ready)) gap_err++;
      gap_chk = 0;
      if (a_ready && b_ready) gap_err++;
      had = (q.size() != 0);
      if ((a_valid && a_ready) || (b_valid && b_ready)) begin
        q.push_back(a_ready ? a_dout : b_dout);
        if (acc_fb == 1023) begin
          fin_cyc = cyc; fin_ok = 1; gap_chk = 1; acc_fb = 0;
        end else acc_fb++;
      end
      if (mag_in_valid) begin
        if (had) e = q.pop_front();
        else begin e = 0; pad_cnt++; end
        if (mag_in_dout !== e) data_err++;
        out_beats++;
        if (mag_in_last) begin
          last_cnt++;
          if (fb != 1023) len_err++;
          fb = 0; acc_fb = 0;
        end else fb++;
      end
      if (wr_valid) wr_cnt++;
      if (frame_done_a || frame_done_b) begin
        seq = {seq[30:0], wr_chan};
        if (frame_done_b != wr_chan) lat_err++;
        if (frame_done_a && frame_done_b) lat_err++;
        if (fin_ok) begin
          last_lat = cyc - fin_cyc;
          if (last_lat != 6) lat_err++;
        end
        fin_ok = 0;
        if (frame_done_a) done_a++; else done_b++;
      end
    end
  end

  task automatic drv(input bit ch, input bit v, input int k, input bit l);
    if (ch) begin
      b_valid = v; b_dout = {16'hBBBB, 6'd0, 10'(k)}; b_last = l;
    end else begin
      a_valid = v; a_dout = {16'hAAAA, 6'd0, 10'(k)}; a_last = l;
    end
  endtask

  task automatic src(input bit ch, input int nfr, input int gap_at,
                     input int gap_len, input int bad_at,
                     input int stop_at);
    int k, g, n;
    bit acc, gv;
    for (int f = 0; f < nfr; f++) begin
      k = 0; g = 0; n = 0;
      while (k < 1024 && k != stop_at) begin
        gv = !(k == gap_at && g < gap_len);
        drv(ch, gv, k, (k == 1023) ^ (k == bad_at));
        @(negedge clk);
        acc = ch ? (b_valid && b_ready) : (a_valid && a_ready);
        @(posedge clk); #1;
        if (acc) k++;
        else if (!gv) g++;
        n++;
        if (n > 4000) begin
          chk("src_stall", n, 0);
          drv(ch, 0, 0, 0);
          return;
        end
      end
    end
    drv(ch, 0, 0, 0);
  endtask

  function automatic logic [10:0] outs();
    return {a_ready, b_ready, mag_in_valid, mag_in_last, wr_chan,
            wr_valid, frame_done_a, frame_done_b, last_err,
            timeout_flag, busy};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  int b0, l0, d0, w0, p0;

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0);
    drv(1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 32'(outs()), 0);
    chk("rst_dout", mag_in_dout, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // tie from reset: A,B,A,B
    d0 = done_a + done_b; w0 = wr_cnt;
    fork
      src(0, 2, -1, 0, -1, -1);
      src(1, 2, -1, 0, -1, -1);
    join
    repeat (10) @(posedge clk);
    #1;
    chk("tie_seq", seq[3:0], 4'b0101);
    chk("tie_frames", done_a + done_b - d0, 4);
    chk("tie_wr_beats", wr_cnt - w0, 4096);
    chk("tie_gap", gap_err, 0);
    chk("tie_len", len_err, 0);

    // single A frame with grant timing
    b0 = out_beats; l0 = last_cnt; d0 = done_a;
    drv(0, 1, 0, 0);
    @(negedge clk);
    chk("grant_pre_rdy", a_ready, 0);
    @(posedge clk); #1;
    chk("grant_rdy", a_ready, 1);
    chk("grant_busy", busy, 1);
    src(0, 1, -1, 0, -1, -1);
    repeat (10) @(posedge clk);
    #1;
    chk("a_beats", out_beats - b0, 1024);
    chk("a_last", last_cnt - l0, 1);
    chk("a_done", done_a - d0, 1);
    chk("a_done_lat", last_lat, 6);
    chk("a_last_err", last_err, 0);
    chk("a_idle", busy, 0);

    // B frame with a 10-cycle gap at beat 300
    b0 = out_beats; d0 = done_b;
    src(1, 1, 300, 10, -1, -1);
    repeat (10) @(posedge clk);
    #1;
    chk("gap_beats", out_beats - b0, 1024);
    chk("gap_done_b", done_b - d0, 1);
    chk("gap_data", data_err, 0);

    // A frame with early last at beat 500
    l0 = last_cnt;
    src(0, 1, -1, 0, 500, -1);
    repeat (10) @(posedge clk);
    #1;
    chk("bad_last_err", last_err, 1);
    chk("bad_last_end", last_cnt - l0, 1);
    chk("bad_len", len_err, 0);

    // reset mid-frame at beat 400
    src(0, 1, -1, 0, -1, 400);
    chk("sticky_err", last_err, 1);
    chk("pre_rst_valid", mag_in_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs()), 0);
    chk("mid_rst_dout", mag_in_dout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    fork
      src(0, 1, -1, 0, -1, -1);
      src(1, 1, -1, 0, -1, -1);
      begin
        int n = 0;
        @(negedge clk);
        while (!mag_in_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("rst_first_beat", mag_in_dout, 32'hAAAA_0000);
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("rst_seq", seq[1:0], 2'b01);
    chk("rst_len", len_err, 0);

`ifdef SPEC_SCHED_TIMEOUT_EN
    b0 = out_beats; d0 = done_a; p0 = pad_cnt;
    src(0, 1, -1, 0, -1, 100);
    repeat (980) @(posedge clk);
    #1;
    chk("tmo_pad", pad_cnt - p0, 924);
    chk("tmo_beats", out_beats - b0, 1024);
    chk("tmo_flag", timeout_flag, 1);
    chk("tmo_done_a", done_a - d0, 1);
    chk("tmo_idle", busy, 0);
`else
    chk("no_pad", pad_cnt, 0);
    chk("no_tmo_flag", timeout_flag, 0);
`endif

    chk("all_data", data_err, 0);
    chk("all_lat", lat_err, 0);
    chk("all_gap", gap_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
